// File: rtl/am_insert_module.sv
// Per-lane TX alignment-marker inserter: replaces one 66-bit slot per period with
// the lane marker, carrying BIP3/BIP7 over every block sent since the previous marker.
module am_insert_module #(
  parameter int NB_CODED_BLOCK = 66,
  parameter int NB_AM          = 48,
  parameter int NB_AM_PERIOD   = 16,
  parameter int NB_BIP         = 8,
  parameter int NB_AM_COUNTER  = 32
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_rf_enable,
  input  logic                      i_valid,
  input  logic [NB_CODED_BLOCK-1:0] i_data,
  input  logic [NB_AM-1:0]          i_rf_am_value,
  input  logic [NB_AM_PERIOD-1:0]   i_rf_am_period,
  output logic                      o_ready,
  output logic [NB_CODED_BLOCK-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_am_insert,
  output logic [NB_AM_COUNTER-1:0]  o_am_counter
);

  localparam int NB_PAYLOAD = NB_CODED_BLOCK - 2;
  localparam int NB_WORDS   = NB_PAYLOAD / NB_BIP;
  localparam int NB_HALF_AM = NB_AM / 2;

  logic [NB_AM_PERIOD-1:0]   slot_q,   slot_d;
  logic [NB_BIP-1:0]         acc_q,    acc_d;
  logic [NB_CODED_BLOCK-1:0] data_q,   data_d;
  logic                      valid_q,  valid_d;
  logic                      am_ins_q, am_ins_d;
  logic [NB_AM_COUNTER-1:0]  am_cnt_q, am_cnt_d;

  logic [NB_AM_PERIOD-1:0]   period_last;
  logic                      am_slot;
  logic [NB_BIP-1:0]         bip3;
  logic [NB_CODED_BLOCK-1:0] am_block;

  // Bit-interleaved parity of one block; the two sync-header bits fold into lanes 3 and 4.
  function automatic logic [NB_BIP-1:0] block_parity(input logic [NB_CODED_BLOCK-1:0] blk);
    logic [NB_BIP-1:0] p;
    p = '0;
    for (int i = 0; i < NB_BIP; i++) begin
      for (int m = 0; m < NB_WORDS; m++) begin
        p[i] = p[i] ^ blk[i + NB_BIP*m];
      end
    end
    p[3] = p[3] ^ blk[NB_CODED_BLOCK-2];
    p[4] = p[4] ^ blk[NB_CODED_BLOCK-1];
    return p;
  endfunction

  assign period_last = (i_rf_am_period < NB_AM_PERIOD'(2)) ? NB_AM_PERIOD'(1)
                                                           : i_rf_am_period - NB_AM_PERIOD'(1);

  // A slot beyond a freshly lowered period behaves as slot 0, so the marker goes out at once.
  assign am_slot = (slot_q == '0) || (slot_q > period_last);

  assign bip3     = acc_q;
  assign am_block = {2'b10,
                     i_rf_am_value[NB_AM-1:NB_HALF_AM], bip3,
                     i_rf_am_value[NB_HALF_AM-1:0],     ~bip3};

  assign o_ready = ~(i_rf_enable && am_slot);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    slot_d   = slot_q;
    acc_d    = acc_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    am_ins_d = am_ins_q;
    am_cnt_d = am_cnt_q;

    if (!i_rf_enable) begin
      slot_d   = '0;
      acc_d    = '0;
      am_ins_d = 1'b0;
      valid_d  = i_valid;
      if (i_valid) begin
        data_d = i_data;
      end
    end else if (i_valid) begin
      valid_d = 1'b1;
      if (am_slot) begin
        data_d   = am_block;
        acc_d    = block_parity(am_block);
        am_ins_d = 1'b1;
        am_cnt_d = am_cnt_q + NB_AM_COUNTER'(1);
        slot_d   = NB_AM_PERIOD'(1);
      end else begin
        data_d   = i_data;
        acc_d    = acc_q ^ block_parity(i_data);
        am_ins_d = 1'b0;
        slot_d   = (slot_q >= period_last) ? '0 : slot_q + NB_AM_PERIOD'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slot_q   <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      am_ins_q <= 1'b0;
      am_cnt_q <= '0;
    end else begin
      slot_q   <= slot_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      am_ins_q <= am_ins_d;
      am_cnt_q <= am_cnt_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_am_insert  = am_ins_q;
  assign o_am_counter = am_cnt_q;

endmodule
